// File: rtl/maxpool_pkg.sv
// Shared FP16 definitions for the 2x2 stride-2 max-pool stage.
package maxpool_pkg;

    localparam int unsigned EXP_W    = 5;
    localparam int unsigned MANT_W   = 10;
    localparam int unsigned MAG_W    = EXP_W + MANT_W;
    localparam int unsigned SIGN_BIT = MAG_W;
    localparam int unsigned FP16_W   = MAG_W + 1;

    typedef logic [FP16_W-1:0] fp16;

    localparam fp16 FP16_POS_ZERO = 16'h0000;
    localparam fp16 FP16_QNAN     = 16'h7E00;

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic fp16_is_nan(input fp16 x);
        return (&x[MAG_W-1:MANT_W]) && (|x[MANT_W-1:0]);
    endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational FP16 max of two bit patterns; a wins ties.
// NaN propagation to canonical 0x7E00 is built only when MAXPOOL_NAN_EN is defined.
module fp16_max2
    import maxpool_pkg::*;
(
    input  fp16 a,
    input  fp16 b,
    output fp16 max_c
);

    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;

    assign mag_a = a[MAG_W-1:0];
    assign mag_b = b[MAG_W-1:0];

    always_comb begin
        max_c = a;
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            // -0/+0 must resolve to +0; otherwise the non-negative operand wins
            if ((mag_a == '0) && (mag_b == '0)) begin
                max_c = FP16_POS_ZERO;
            end else begin
                max_c = a[SIGN_BIT] ? b : a;
            end
        end else if (!a[SIGN_BIT]) begin
            max_c = (mag_b > mag_a) ? b : a;
        end else begin
            max_c = (mag_b < mag_a) ? b : a;
        end
`ifdef MAXPOOL_NAN_EN
        if (fp16_is_nan(a) || fp16_is_nan(b)) begin
            max_c = FP16_QNAN;
        end
`endif
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 FP16 max-pool holding one row of horizontal maxima.
// Optional NaN propagation lives in fp16_max2 under MAXPOOL_NAN_EN.
module maxpool2x2_stream
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned H          = 4,
    parameter int unsigned W          = 4,
    parameter int unsigned K          = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done
);

    localparam int unsigned COL_W  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned ROW_W  = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned CH_W   = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned BUF_D  = W / 2;
    localparam int unsigned BUF_AW = (BUF_D > 1) ? $clog2(BUF_D) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q,  ch_d;
    fp16              hreg_q, hreg_d;
    fp16              rowbuf_q [BUF_D];
    fp16              rowbuf_d [BUF_D];
    fp16              out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic             frame_done_q, frame_done_d;

    logic              in_fire;
    logic              out_fire;
    logic              col_last;
    logic              row_last;
    logic              ch_last;
    logic [BUF_AW-1:0] buf_idx;
    fp16               hmax;
    fp16               vmax;

    assign in_ready   = !out_valid_q || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;
    assign col_last   = (col_q == COL_W'(W - 1));
    assign row_last   = (row_q == ROW_W'(H - 1));
    assign ch_last    = (ch_q == CH_W'(K - 1));
    assign buf_idx    = BUF_AW'(col_q >> 1);

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

    fp16_max2 u_hmax (
        .a     (hreg_q),
        .b     (in_data),
        .max_c (hmax)
    );

    fp16_max2 u_vmax (
        .a     (rowbuf_q[buf_idx]),
        .b     (hmax),
        .max_c (vmax)
    );

    // Next-state: counters, row buffer and output register
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        ch_d         = ch_q;
        hreg_d       = hreg_q;
        rowbuf_d     = rowbuf_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        last_d       = last_q;
        frame_done_d = 1'b0;

        if (out_fire) begin
            out_valid_d  = 1'b0;
            frame_done_d = last_q;
        end

        if (in_fire) begin
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
                if (row_last) begin
                    ch_d = ch_last ? '0 : ch_q + CH_W'(1);
                end
            end

            if (!col_q[0]) begin
                hreg_d = in_data;
            end else if (!row_q[0]) begin
                rowbuf_d[buf_idx] = hmax;
            end else begin
                // A fresh result overrides the clear from a same-edge output transfer
                out_data_d  = vmax;
                out_valid_d = 1'b1;
                last_d      = ch_last && row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            hreg_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            hreg_q       <= hreg_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row buffer is always written before it is read, so it needs no reset
    always_ff @(posedge clk) begin
        rowbuf_q <= rowbuf_d;
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed self-checking bench for maxpool2x2_stream (H=W=4, K=2).
module tb_maxpool2x2_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] got [$];
    int          fd_cnt = 0;
    int          fd_at  = 0;

`ifdef MAXPOOL_NAN_EN
    localparam logic [15:0] NAN_EXP = 16'h7E00;
`else
    localparam logic [15:0] NAN_EXP = 16'h7C01;
`endif

    logic [15:0] pl [4][16];
    logic [15:0] exp_a [4] = '{16'h4000, 16'h4200, 16'h4400, 16'h3800};
    logic [15:0] exp_b [4] = '{16'h0000, 16'hB800, 16'h0000, NAN_EXP};

    always #5 clk = ~clk;

    maxpool2x2_stream #(
        .DATA_WIDTH (16),
        .H          (4),
        .W          (4),
        .K          (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    // Capture output transfers and frame_done pulses away from the clock edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt = fd_cnt + 1;
            fd_at  = got.size();
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
    end

    // Independent reference: map patterns to a signed ordering key, -0 below +0
    function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b);
        int ka;
        int kb;
`ifdef MAXPOOL_NAN_EN
        if ((a[14:10] == 5'h1F && a[9:0] != 10'h0) || (b[14:10] == 5'h1F && b[9:0] != 10'h0))
            return 16'h7E00;
`endif
        ka = a[15] ? -int'(a[14:0]) - 1 : int'(a[14:0]);
        kb = b[15] ? -int'(b[14:0]) - 1 : int'(b[14:0]);
        return (kb > ka) ? b : a;
    endfunction

    function automatic logic [15:0] ref_pool(input int s, input int r, input int c);
        logic [15:0] top;
        logic [15:0] bot;
        top = ref_max(pl[s][(2*r)*4 + 2*c], pl[s][(2*r)*4 + 2*c + 1]);
        bot = ref_max(pl[s][(2*r+1)*4 + 2*c], pl[s][(2*r+1)*4 + 2*c + 1]);
        return ref_max(top, bot);
    endfunction

    task automatic push(input logic [15:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    // Plane 0 with per-element latency checks
    task automatic test_plane0();
        logic exp_v;
        got.delete();
        fd_cnt    = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(pl[0][i]);
            exp_v = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
            n_vec++;
            if (out_valid !== exp_v) begin
                n_err++;
                $display("FAIL p0_valid[%0d]: got %b want %b", i, out_valid, exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if (out_data !== exp_a[((i / 4) / 2) * 2 + (i % 4) / 2]) begin
                    n_err++;
                    $display("FAIL p0_data[%0d]: got %h want %h", i, out_data, exp_a[((i / 4) / 2) * 2 + (i % 4) / 2]);
                end
            end
        end
        drain();
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL p0_count: got %0d want 4", got.size()); end
        n_vec++; if (fd_cnt != 0) begin n_err++; $display("FAIL p0_frame_done: got %0d pulses want 0", fd_cnt); end
    endtask

    // Plane 1 holds sign, zero and NaN cases; it completes the frame
    task automatic test_sign_cases();
        for (int i = 0; i < 16; i++) push(pl[1][i]);
        drain();
        n_vec++;
        if (got.size() != 8) begin
            n_err++;
            $display("FAIL sign_count: got %0d want 8", got.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (got[4 + j] !== exp_b[j]) begin
                    n_err++;
                    $display("FAIL sign_data[%0d]: got %h want %h", j, got[4 + j], exp_b[j]);
                end
            end
        end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL sign_fd_cnt: got %0d want 1", fd_cnt); end
        n_vec++; if (fd_at != 8) begin n_err++; $display("FAIL sign_fd_at: got %0d want 8", fd_at); end
    endtask

    task automatic test_back_to_back();
        got.delete();
        fd_cnt    = 0;
        out_ready = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) push(pl[s][i]);
        drain();
        n_vec++;
        if (got.size() != 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 8", got.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_vec++;
                if (got[j] !== ((j < 4) ? exp_a[j] : exp_b[j - 4])) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", j, got[j], (j < 4) ? exp_a[j] : exp_b[j - 4]);
                end
            end
        end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL b2b_fd_cnt: got %0d want 1", fd_cnt); end
        n_vec++; if (fd_at != 8) begin n_err++; $display("FAIL b2b_fd_at: got %0d want 8", fd_at); end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int          g;
        got.delete();
        fd_cnt    = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int s = 2; s < 4; s++)
                    for (int i = 0; i < 16; i++) push(pl[s][i]);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                g = 0;
                @(negedge clk);
                while (out_valid !== 1'b1 && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_wait_valid: out_valid=%b required 1 within 50 cycles", out_valid);
                end
                held = out_data;
                n_vec++;
                if (held !== ref_pool(2, 0, 0)) begin
                    n_err++;
                    $display("FAIL bp_first: got %h want %h", held, ref_pool(2, 0, 0));
                end
                for (int k = 0; k < 5; k++) begin
                    n_vec++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                        n_err++;
                        $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b out_data=%h want 0 1 %h",
                                 k, in_ready, out_valid, out_data, held);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        n_vec++;
        if (got.size() != 8) begin
            n_err++;
            $display("FAIL bp_count: got %0d want 8", got.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_vec++;
                if (got[j] !== ref_pool(2 + j / 4, (j % 4) / 2, j % 2)) begin
                    n_err++;
                    $display("FAIL bp_data[%0d]: got %h want %h", j, got[j], ref_pool(2 + j / 4, (j % 4) / 2, j % 2));
                end
            end
        end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL bp_fd_cnt: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_reset_midframe();
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(pl[0][i]);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", out_valid); end
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_frame_done: got %b want 0", frame_done); end
        out_ready = 1'b1;
        got.delete();
        fd_cnt = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) push(pl[s][i]);
        drain();
        n_vec++;
        if (got.size() != 8) begin
            n_err++;
            $display("FAIL mid_count: got %0d want 8", got.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_vec++;
                if (got[j] !== ((j < 4) ? exp_a[j] : exp_b[j - 4])) begin
                    n_err++;
                    $display("FAIL mid_data[%0d]: got %h want %h", j, got[j], (j < 4) ? exp_a[j] : exp_b[j - 4]);
                end
            end
        end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL mid_fd_cnt: got %0d want 1", fd_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;

        pl[0] = '{16'h3C00, 16'h4000, 16'h3800, 16'h0000,
                  16'hBC00, 16'h3C00, 16'h4200, 16'h3C00,
                  16'h0000, 16'h0000, 16'h3800, 16'h3800,
                  16'h3C00, 16'h4400, 16'hBC00, 16'h0000};
        pl[1] = '{16'hBC00, 16'h8000, 16'hBC00, 16'hC000,
                  16'h0000, 16'hC000, 16'hB800, 16'hC200,
                  16'h8000, 16'h0000, 16'h7C01, 16'h3C00,
                  16'h0000, 16'h8000, 16'h3C00, 16'h3C00};
        for (int i = 0; i < 16; i++) begin
            pl[2][i] = 16'(i * 16'h0B3D + 16'h1234);
            pl[3][i] = 16'(16'hC100 - i * 16'h0457);
        end

        test_reset();
        test_plane0();
        test_sign_cases();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
